// File: rtl/cali_pkg.sv
// Shared state encoding, parameter defaults and datapath width helpers for the
// calibration lookup sequencer.
package cali_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_OFF,
        RD_GAIN,
        CALC,
        OUT
    } cali_state_e;

    localparam int DATA_W_DEF    = 16;
    localparam int COEF_FRAC_DEF = 14;
    localparam int OFFS_BASE_DEF = 0;
    localparam int GAIN_BASE_DEF = 256;

    // diff keeps one extra bit so raw - offset never overflows
    function automatic int cali_diff_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int cali_prod_w(input int data_w);
        return 2 * (data_w + 1);
    endfunction

endpackage

// File: rtl/cali_mac.sv
// Combinational correction datapath: ((raw - offset) * gain + half) >>> COEF_FRAC.
// Build option CALI_SAT_EN clamps to the signed DATA_W range; otherwise the result wraps.
module cali_mac
    import cali_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF
) (
    input  logic [DATA_W-1:0] i_raw,
    input  logic [DATA_W-1:0] i_offset,
    input  logic [DATA_W-1:0] i_gain,
    output logic [DATA_W-1:0] o_res,
    output logic              o_sat
);

    localparam int DIFF_W = cali_diff_w(DATA_W);
    localparam int PROD_W = cali_prod_w(DATA_W);
    localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (COEF_FRAC - 1);

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [DIFF_W-1:0] w_gain;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_rnd;

    assign w_diff = $signed({i_raw[DATA_W-1], i_raw}) - $signed({i_offset[DATA_W-1], i_offset});
    assign w_gain = $signed({1'b0, i_gain});
    assign w_prod = PROD_W'(w_diff) * PROD_W'(w_gain);
    assign w_rnd  = (w_prod + RND_HALF) >>> COEF_FRAC;

`ifdef CALI_SAT_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        o_res = w_rnd[DATA_W-1:0];
        o_sat = 1'b0;
        if (w_rnd > SAT_MAX) begin
            o_res = SAT_MAX[DATA_W-1:0];
            o_sat = 1'b1;
        end else if (w_rnd < SAT_MIN) begin
            o_res = SAT_MIN[DATA_W-1:0];
            o_sat = 1'b1;
        end
    end
`else
    logic w_unused_hi;

    assign o_res       = w_rnd[DATA_W-1:0];
    assign o_sat       = 1'b0;
    assign w_unused_hi = ^w_rnd[PROD_W-1:DATA_W];
`endif

endmodule

// File: rtl/cali_lookup_seq.sv
// Per-sample calibration sequencer: tracks channel within frame, fetches offset/gain
// from the calibration RAM read port and emits the corrected sample. Option: CALI_SAT_EN.
//
// state   | meaning
// IDLE    | s_ready high, waiting for a raw sample
// RD_OFF  | offset address on RAM port
// RD_GAIN | gain address on RAM port, offset captured
// CALC    | gain arrives, corrected result registered
// OUT     | m_valid high, held until m_ready
module cali_lookup_seq
    import cali_pkg::*;
#(
    parameter int N_CH      = 64,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int OFFS_BASE = OFFS_BASE_DEF,
    parameter int GAIN_BASE = GAIN_BASE_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_sat,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic [1:0]        ram_byteenable,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              err_frame,
    input  logic              err_clr
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [ADDR_W-1:0] OFFS_ADDR = ADDR_W'(OFFS_BASE);
    localparam logic [ADDR_W-1:0] GAIN_ADDR = ADDR_W'(GAIN_BASE);

    cali_state_e       r_state;
    logic              r_s_ready;
    logic [DATA_W-1:0] r_raw;
    logic              r_sof;
    logic [DATA_W-1:0] r_offset;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_ch_cur;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_sof;
    logic              r_m_sat;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_ram_cs;
    logic              r_ram_clken;
    logic              r_err;

    logic              w_accept;
    logic [CH_W-1:0]   w_ch_res;
    logic [CH_W-1:0]   w_ch_nxt;
    logic              w_err_new;
    logic [DATA_W-1:0] w_mac_res;
    logic              w_mac_sat;

    // r_ch is the channel expected next; sof forces 0, and an unexpected wrap is also channel 0
    assign w_accept  = (r_state == IDLE) && r_s_ready && s_valid;
    assign w_ch_res  = s_sof ? '0 : r_ch;
    assign w_ch_nxt  = (w_ch_res == CH_LAST) ? '0 : w_ch_res + CH_W'(1);
    assign w_err_new = w_accept && (s_sof != (r_ch == '0));

    cali_mac #(
        .DATA_W    (DATA_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_mac (
        .i_raw    (r_raw),
        .i_offset (r_offset),
        .i_gain   (ram_readdata),
        .o_res    (w_mac_res),
        .o_sat    (w_mac_sat)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state       <= IDLE;
            r_s_ready     <= 1'b0;
            r_raw         <= '0;
            r_sof         <= 1'b0;
            r_offset      <= '0;
            r_ch          <= '0;
            r_ch_cur      <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_sof       <= 1'b0;
            r_m_sat       <= 1'b0;
            r_ram_address <= '0;
            r_ram_cs      <= 1'b0;
            r_ram_clken   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= (r_err & ~err_clr) | w_err_new;
            case (r_state)
                IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_s_ready     <= 1'b0;
                        r_raw         <= s_data;
                        r_sof         <= s_sof;
                        r_ch_cur      <= w_ch_res;
                        r_ch          <= w_ch_nxt;
                        r_ram_address <= OFFS_ADDR + ADDR_W'(w_ch_res);
                        r_ram_cs      <= 1'b1;
                        r_ram_clken   <= 1'b1;
                        r_state       <= RD_OFF;
                    end
                end
                RD_OFF: begin
                    r_ram_address <= GAIN_ADDR + ADDR_W'(r_ch_cur);
                    r_state       <= RD_GAIN;
                end
                RD_GAIN: begin
                    r_offset      <= ram_readdata;
                    r_ram_address <= '0;
                    r_ram_cs      <= 1'b0;
                    r_state       <= CALC;
                end
                CALC: begin
                    // clken stays high through here so the gain word can be captured
                    r_ram_clken <= 1'b0;
                    r_m_data    <= w_mac_res;
                    r_m_sat     <= w_mac_sat;
                    r_m_sof     <= r_sof;
                    r_m_valid   <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready        = r_s_ready;
    assign m_valid        = r_m_valid;
    assign m_data         = r_m_data;
    assign m_sof          = r_m_sof;
    assign m_sat          = r_m_sat;
    assign ram_address    = r_ram_address;
    assign ram_chipselect = r_ram_cs;
    assign ram_clken      = r_ram_clken;
    assign ram_write      = 1'b0;
    assign ram_writedata  = '0;
    assign ram_byteenable = 2'b11;
    assign err_frame      = r_err;

endmodule

// File: tb/tb_cali_lookup_seq.sv
// Directed bench for cali_lookup_seq with a 4-channel frame and a registered-read RAM model.
module tb_cali_lookup_seq;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 9;
    localparam int GAIN_BASE = 256;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_sat;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_clken;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [1:0]        ram_byteenable;
    logic [DATA_W-1:0] ram_readdata = '0;
    logic              err_frame;
    logic              err_clr;

    logic [DATA_W-1:0] mem [0:511];
    logic [ADDR_W-1:0] off_log [$];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk_clk = ~clk_clk;

    cali_lookup_seq #(
        .N_CH (4)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_sof          (s_sof),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_sof          (m_sof),
        .m_sat          (m_sat),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_clken      (ram_clken),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_readdata   (ram_readdata),
        .err_frame      (err_frame),
        .err_clr        (err_clr)
    );

    always @(posedge clk_clk) begin
        if (ram_chipselect && ram_clken) ram_readdata <= mem[ram_address];
    end

    always @(negedge clk_clk) begin
        if (reset_reset_n && ram_chipselect && ram_address < ADDR_W'(GAIN_BASE))
            off_log.push_back(ram_address);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_coef(input logic [DATA_W-1:0] off, input logic [DATA_W-1:0] gain);
        for (int c = 0; c < 4; c++) begin
            mem[c]             = off;
            mem[GAIN_BASE + c] = gain;
        end
    endtask

    task automatic xfer(input string tag, input logic [DATA_W-1:0] d, input logic sof,
                        input logic [DATA_W-1:0] exp_d, input logic exp_sof,
                        input logic exp_sat, input int hold);
        int n;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk_clk); #1;
            n++;
        end
        chk({tag, "_rdy"}, 32'(s_ready), 32'(1));
        m_ready = (hold == 0);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        @(posedge clk_clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk({tag, "_srdy_lo"}, 32'(s_ready), 32'(0));
        n = 1;
        while (!m_valid && n < 12) begin
            @(posedge clk_clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(4));
        chk({tag, "_data"}, 32'(m_data), 32'(exp_d));
        chk({tag, "_sof"}, 32'(m_sof), 32'(exp_sof));
        chk({tag, "_sat"}, 32'(m_sat), 32'(exp_sat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_clk); #1;
            chk({tag, "_hold_valid"}, 32'(m_valid), 32'(1));
            chk({tag, "_hold_data"}, 32'(m_data), 32'(exp_d));
            chk({tag, "_hold_sof"}, 32'(m_sof), 32'(exp_sof));
            chk({tag, "_hold_srdy"}, 32'(s_ready), 32'(0));
            chk({tag, "_hold_cs"}, 32'(ram_chipselect), 32'(0));
        end
        m_ready = 1'b1;
        @(posedge clk_clk); #1;
        chk({tag, "_done"}, 32'(m_valid), 32'(0));
        chk({tag, "_idle_rdy"}, 32'(s_ready), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] exp_ovf;
        logic              exp_ovf_sat;
        logic              saw_valid;
        logic [ADDR_W-1:0] a;

        reset_reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        err_clr = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;

        // reset state
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_m_sof", 32'(m_sof), 32'(0));
        chk("rst_m_sat", 32'(m_sat), 32'(0));
        chk("rst_addr", 32'(ram_address), 32'(0));
        chk("rst_cs", 32'(ram_chipselect), 32'(0));
        chk("rst_clken", 32'(ram_clken), 32'(0));
        chk("rst_err", 32'(err_frame), 32'(0));
        chk("rst_write", 32'(ram_write), 32'(0));
        chk("rst_wdata", 32'(ram_writedata), 32'(0));
        chk("rst_be", 32'(ram_byteenable), 32'(3));
        reset_reset_n = 1'b1;
        #1;
        chk("rel_s_ready_lo", 32'(s_ready), 32'(0));
        @(posedge clk_clk); #1;
        chk("rel_s_ready_hi", 32'(s_ready), 32'(1));

        // frame wrap: sof on samples 1, 5 and 9 keeps the 4-channel frame aligned
        set_coef(16'd0, 16'd16384);
        off_log.delete();
        for (int i = 1; i <= 9; i++) begin
            xfer("wrap", 16'(i * 100), (i == 1 || i == 5 || i == 9),
                 16'(i * 100), (i == 1 || i == 5 || i == 9), 1'b0, 0);
        end
        chk("wrap_log_n", 32'(off_log.size()), 32'(9));
        for (int k = 0; k < 9; k++) begin
            a = (k < off_log.size()) ? off_log[k] : '1;
            chk($sformatf("wrap_addr%0d", k), 32'(a), 32'(k % 4));
        end
        chk("wrap_err", 32'(err_frame), 32'(0));

        // sof on the third sample of a frame
        off_log.delete();
        xfer("f2", 16'd10, 1'b0, 16'd10, 1'b0, 1'b0, 0);
        chk("f2_err", 32'(err_frame), 32'(0));
        xfer("f3", 16'd20, 1'b1, 16'd20, 1'b1, 1'b0, 0);
        chk("f3_err", 32'(err_frame), 32'(1));
        xfer("f4", 16'd30, 1'b0, 16'd30, 1'b0, 1'b0, 0);
        chk("ferr_log_n", 32'(off_log.size()), 32'(3));
        for (int k = 0; k < 3; k++) begin
            a = (k < off_log.size()) ? off_log[k] : '1;
            chk($sformatf("ferr_addr%0d", k), 32'(a), 32'((k == 1) ? 0 : 1));
        end
        err_clr = 1'b1;
        @(posedge clk_clk); #1;
        err_clr = 1'b0;
        chk("err_clr", 32'(err_frame), 32'(0));

        // unity gain with offset
        set_coef(16'd100, 16'd16384);
        xfer("unity", 16'd1100, 1'b1, 16'd1000, 1'b1, 1'b0, 0);

        // half gain, round half up
        set_coef(16'd0, 16'd8192);
        xfer("rnd_p3", 16'd3, 1'b0, 16'd2, 1'b0, 1'b0, 0);
        xfer("rnd_m3", 16'hFFFD, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
        xfer("rnd_p1", 16'd1, 1'b0, 16'd1, 1'b0, 1'b0, 0);

        // backpressure
        set_coef(16'd0, 16'd16384);
        xfer("bp", 16'd1234, 1'b1, 16'd1234, 1'b1, 1'b0, 10);

        // overflow: 32767 - (-32768) = 65535
`ifdef CALI_SAT_EN
        exp_ovf     = 16'h7FFF;
        exp_ovf_sat = 1'b1;
`else
        exp_ovf     = 16'hFFFF;
        exp_ovf_sat = 1'b0;
`endif
        set_coef(16'h8000, 16'd16384);
        xfer("ovf", 16'h7FFF, 1'b0, exp_ovf, 1'b0, exp_ovf_sat, 0);

        // reset during RD_GAIN of a channel-1 sample
        set_coef(16'd0, 16'd16384);
        xfer("pre_rst", 16'd5, 1'b1, 16'd5, 1'b1, 1'b0, 0);
        s_valid = 1'b1;
        s_data  = 16'd9;
        s_sof   = 1'b0;
        @(posedge clk_clk); #1;
        s_valid = 1'b0;
        @(posedge clk_clk); #1;
        chk("mid_gain_addr", 32'(ram_address), 32'(GAIN_BASE + 1));
        chk("mid_gain_clken", 32'(ram_clken), 32'(1));
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(ram_chipselect), 32'(0));
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk_clk); #1;
            if (m_valid) saw_valid = 1'b1;
        end
        chk("mid_rst_no_valid", 32'(saw_valid), 32'(0));
        off_log.delete();
        xfer("post_rst", 16'd7, 1'b0, 16'd7, 1'b0, 1'b0, 0);
        a = (off_log.size() > 0) ? off_log[0] : '1;
        chk("post_rst_addr", 32'(a), 32'(0));
        chk("post_rst_err", 32'(err_frame), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
